// File: rtl/controle_contador_pkg.sv
// Shared types and helpers for the controle_contador sequencer and its counter datapath.
package controle_contador_pkg;

  localparam int NBITS_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // All-zeros when counting up, all-ones when counting down; callers truncate to their width.
  function automatic logic [31:0] init_value(input logic up);
    return up ? 32'd0 : 32'hFFFF_FFFF;
  endfunction

endpackage

// File: rtl/contador_updown.sv
// NBITS up/down counter register: load has priority over enable; one step per enabled cycle.
module contador_updown #(
  parameter int NBITS = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [NBITS-1:0] i_load_val,
  input  logic             i_en,
  input  logic             i_up,
  output logic [NBITS-1:0] o_count
);

  logic [NBITS-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en) begin
      r_count <= i_up ? r_count + NBITS'(1) : r_count - NBITS'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/controle_contador.sv
// Start/pause/stop sequencer driving contador_updown from its initial value to a latched limit.
// CONTROLE_CONTADOR_AUTO_RELOAD_EN: on terminal, pulse done, reload init and keep running.
module controle_contador
  import controle_contador_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             up,
  input  logic [NBITS-1:0] limit,
  input  logic             pause,
  input  logic             stop,
  output logic [NBITS-1:0] count,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  state_t           w_next;
  logic             r_dir;
  logic [NBITS-1:0] r_lim;
  logic             r_done;
  logic             w_load;
  logic             w_en;
  logic             w_done_nxt;
  logic [NBITS-1:0] w_load_val;
  logic [NBITS-1:0] w_count;

  contador_updown #(.NBITS(NBITS)) u_contador (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_en       (w_en),
    .i_up       (r_dir),
    .o_count    (w_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_dir   <= 1'b0;
      r_lim   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= w_done_nxt;
      if (r_state == S_IDLE && start) begin
        r_dir <= up;
        r_lim <= limit;
      end
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = NBITS'(init_value(up));
    w_en       = 1'b0;
    w_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        // Terminal outranks pause so a run never parks on its last value.
        if (stop) begin
          w_next = S_IDLE;
        end else if (w_count == r_lim) begin
          w_done_nxt = 1'b1;
`ifdef CONTROLE_CONTADOR_AUTO_RELOAD_EN
          w_load     = 1'b1;
          w_load_val = NBITS'(init_value(r_dir));
`else
          w_next     = S_DONE;
`endif
        end else if (pause) begin
          w_next = S_HOLD;
        end else begin
          w_en = 1'b1;
        end
      end
      S_HOLD: begin
        if (stop) begin
          w_next = S_IDLE;
        end else if (!pause) begin
          w_next = S_RUN;
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign count = w_count;
  assign busy  = (r_state == S_RUN) || (r_state == S_HOLD);
  assign done  = r_done;

endmodule

// File: tb/tb_controle_contador.sv
// Bench for controle_contador: vector table, directed corner sequences, random run vs. reference model.
module tb_controle_contador;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       up = 1'b0;
  logic [3:0] limit = 4'd0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] count;
  logic       busy;
  logic       done;

  int n_chk = 0;
  int n_pass = 0;

  controle_contador #(.NBITS(4)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .up    (up),
    .limit (limit),
    .pause (pause),
    .stop  (stop),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: a run is "active", possibly "held", with a position and a signed step.
  bit m_active = 0, m_held = 0, m_fin = 0, m_done = 0;
  int m_pos = 0, m_lim = 0, m_step = 0;

  task automatic model_edge();
    if (reset) begin
      m_active = 0; m_held = 0; m_fin = 0; m_done = 0;
      m_pos = 0; m_lim = 0; m_step = 0;
      return;
    end
    m_done = 0;
    if (m_fin) begin
      m_fin = 0;
    end else if (!m_active) begin
      if (start) begin
        m_step = up ? 1 : -1;
        m_lim = int'(limit);
        m_pos = up ? 0 : 15;
        m_active = 1;
        m_held = 0;
      end
    end else if (stop) begin
      m_active = 0;
      m_held = 0;
    end else if (m_held) begin
      m_held = pause;
    end else if (m_pos == m_lim) begin
      m_done = 1;
`ifdef CONTROLE_CONTADOR_AUTO_RELOAD_EN
      m_pos = (m_step > 0) ? 0 : 15;
`else
      m_active = 0;
      m_fin = 1;
`endif
    end else if (pause) begin
      m_held = 1;
    end else begin
      m_pos = (m_pos + m_step + 16) % 16;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("mdl_count", int'(count), m_pos);
    chk("mdl_busy", int'(busy), int'(m_active));
    chk("mdl_done", int'(done), int'(m_done));
    chk("busy_done_excl", int'(busy && done), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic do_start(input bit u, input logic [3:0] lim);
    start = 1'b1; up = u; limit = lim;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    bit         up;
    logic [3:0] lim;
    logic [3:0] first;
    int         done_edge;
  } vec_t;

  vec_t vecs[6];

  initial begin
    vecs[0] = '{1'b1, 4'd5,  4'd0,  6};
    vecs[1] = '{1'b0, 4'd12, 4'd15, 4};
    vecs[2] = '{1'b1, 4'd0,  4'd0,  1};
    vecs[3] = '{1'b0, 4'd15, 4'd15, 1};
    vecs[4] = '{1'b1, 4'd15, 4'd0,  16};
    vecs[5] = '{1'b0, 4'd0,  4'd15, 16};

    // Reset state
    do_reset();
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);

`ifndef CONTROLE_CONTADOR_AUTO_RELOAD_EN
    foreach (vecs[v]) begin
      int e;
      int s;
      do_reset();
      do_start(vecs[v].up, vecs[v].lim);
      chk("vec_first", int'(count), int'(vecs[v].first));
      chk("vec_busy", int'(busy), 1);
      s = vecs[v].done_edge - 1;
      e = 0;
      while (e < 40) begin
        int k;
        tick();
        e++;
        k = (e < s) ? e : s;
        chk("vec_seq", int'(count), vecs[v].up ? k : 15 - k);
        if (done) break;
      end
      chk("vec_done_edge", e, vecs[v].done_edge);
      chk("vec_done_busy", int'(busy), 0);
      // start in the DONE cycle must be ignored
      start = 1'b1; up = ~vecs[v].up;
      tick();
      start = 1'b0;
      chk("vec_done_1cyc", int'(done), 0);
      chk("vec_hold_cnt", int'(count), int'(vecs[v].lim));
      chk("vec_idle_busy", int'(busy), 0);
    end

    // Pause at count 3, sampled high on two edges: done slips from edge 10 to edge 13
    begin
      int e;
      do_reset();
      do_start(1'b1, 4'd9);
      repeat (3) tick();
      chk("pz_pre", int'(count), 3);
      pause = 1'b1;
      tick(); chk("pz_hold1", int'(count), 3); chk("pz_busy", int'(busy), 1);
      tick(); chk("pz_hold2", int'(count), 3);
      pause = 1'b0;
      tick(); chk("pz_resume", int'(count), 3);
      tick(); chk("pz_step", int'(count), 4);
      e = 7;
      while (e < 40 && !done) begin
        tick();
        e++;
      end
      chk("pz_done_edge", e, 13);
      chk("pz_final", int'(count), 9);
    end

    // Start while busy ignored; stop at count 2 aborts without done
    do_reset();
    do_start(1'b1, 4'd9);
    start = 1'b1; up = 1'b0; limit = 4'd3;
    tick();
    start = 1'b0;
    chk("busy_start_ign", int'(count), 1);
    tick();
    chk("stop_pre", int'(count), 2);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_busy", int'(busy), 0);
    chk("stop_count", int'(count), 2);
    for (int i = 0; i < 3; i++) begin
      pause = 1'b1; stop = 1'b1;
      tick();
      chk("stop_no_done", int'(done), 0);
      chk("idle_hold", int'(count), 2);
    end
    pause = 1'b0; stop = 1'b0;

    // Reset mid-run
    do_start(1'b1, 4'd9);
    repeat (4) tick();
    chk("mid_pre", int'(count), 4);
    do_reset();
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
`else
    do_reset();
    do_start(1'b1, 4'd2);
    for (int i = 1; i < 10; i++) begin
      tick();
      chk("ar_count", int'(count), i % 3);
      chk("ar_done", int'(done), (i % 3 == 0) ? 1 : 0);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("ar_stop_busy", int'(busy), 0);
`endif

    // Randomized traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      start = ($urandom_range(0, 3) == 0);
      up    = $urandom_range(0, 1);
      limit = 4'($urandom_range(0, 15));
      pause = ($urandom_range(0, 4) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      tick();
    end
    reset = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
